// File: rtl/input_test_pkg.sv
// Shared definitions for the HPS download / CPU read memory arbiter.
package input_test_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 17;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  // Memory targets behind the shared port
  typedef enum logic [1:0] {
    TGT_BIOS   = 2'd0,
    TGT_SPRITE = 2'd1,
    TGT_MUSIC  = 2'd2
  } target_e;

  // ioctl_index values that select a target
  localparam logic [7:0] IDX_BIOS   = 8'd0;
  localparam logic [7:0] IDX_SPRITE = 8'd3;
  localparam logic [7:0] IDX_MUSIC  = 8'd4;

  // Read FSM states
  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

  // One queued download byte
  typedef struct packed {
    target_e            sel;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } dl_entry_t;

endpackage

// File: rtl/dl_mem_arbiter_fifo.sv
// Small download FIFO; a push into a full FIFO is accepted when a pop happens
// in the same cycle.
module dl_fifo
  import input_test_pkg::*;
(
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  dl_entry_t        push_data,
  input  logic             pop,
  output dl_entry_t        pop_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  dl_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage (contents are don't-care after a flush)
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dl_mem_arbiter.sv
// Shares one memory port between HPS download writes and CPU reads.
// The port is driven combinationally from the grant so a CPU read address
// reaches the synchronous memory in the request cycle; it holds its last
// value when nothing is granted.
module dl_mem_arbiter
  import input_test_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [DATA_W-1:0]  ioctl_dout,
  input  logic [7:0]         ioctl_index,
  input  logic               cpu_req,
  input  logic [1:0]         cpu_sel,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ack,
  output logic [DATA_W-1:0]  cpu_dout,
  output logic [1:0]         mem_sel,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_din,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_dout,
  output logic               dl_busy,
  output logic               dl_done,
  output logic [17:0]        dl_bytes,
  output logic               err_range
);

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [CNT_W-1:0]  fifo_count;
  dl_entry_t         fifo_head;
  dl_entry_t         push_entry;
  target_e           dl_sel;
  logic              idx_ok;
  logic              addr_ok;
  logic              push;
  logic              pop;
  logic              cpu_grant;
  logic              dl_prev;
  logic              busy_nxt;
  logic [1:0]        last_sel;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_din;

  // Map the download index onto a memory target
  always_comb begin
    dl_sel = TGT_BIOS;
    idx_ok = 1'b1;
    case (ioctl_index)
      IDX_BIOS:   dl_sel = TGT_BIOS;
      IDX_SPRITE: dl_sel = TGT_SPRITE;
      IDX_MUSIC:  dl_sel = TGT_MUSIC;
      default:    idx_ok = 1'b0;
    endcase
  end

  assign addr_ok    = (ioctl_addr[24:17] == 8'd0);
  assign push       = ioctl_download && ioctl_wr && idx_ok && addr_ok && !reset;
  assign push_entry = '{sel: dl_sel, addr: ioctl_addr[ADDR_W-1:0], data: ioctl_dout};
  assign busy_nxt   = ioctl_download || (fifo_count != '0);

  dl_fifo u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  // Grant arbitration, read FSM next state and memory port drive
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cpu_grant = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = last_sel;
    mem_addr  = last_addr;
    mem_din   = last_din;
    if (!reset) begin
      // A full FIFO must drain first so a same-cycle push is never lost;
      // the ack cycle still counts as the read being outstanding.
      if (fifo_count == CNT_W'(FIFO_DEPTH)) pop = 1'b1;
      else if (cpu_req && (state == IDLE) && !cpu_ack) cpu_grant = 1'b1;
      else if (fifo_count != '0) pop = 1'b1;

      if (pop) begin
        mem_we   = 1'b1;
        mem_sel  = fifo_head.sel;
        mem_addr = fifo_head.addr;
        mem_din  = fifo_head.data;
      end
      if (cpu_grant) begin
        mem_sel   = cpu_sel;
        mem_addr  = cpu_addr;
        state_nxt = RD_WAIT;
      end else if (state == RD_WAIT) begin
        state_nxt = IDLE;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Read completion: one-cycle ack with the memory data from RD_WAIT
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_ack  <= 1'b0;
      cpu_dout <= '0;
    end else begin
      cpu_ack <= (state == RD_WAIT);
      if (state == RD_WAIT) cpu_dout <= mem_dout;
    end
  end

  // Remember the last port drive so it stays stable while idle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_sel  <= '0;
      last_addr <= '0;
      last_din  <= '0;
    end else begin
      last_sel  <= mem_sel;
      last_addr <= mem_addr;
      last_din  <= mem_din;
    end
  end

  // Download status: busy/done, byte counter, sticky range error.
  // dl_prev follows ioctl_download through reset so a download still active
  // at release is not seen as a fresh start.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_prev   <= ioctl_download;
      dl_busy   <= 1'b0;
      dl_done   <= 1'b0;
      dl_bytes  <= '0;
      err_range <= 1'b0;
    end else begin
      dl_prev <= ioctl_download;
      dl_busy <= busy_nxt;
      dl_done <= dl_busy && !busy_nxt;
      if (ioctl_download && !dl_prev)    dl_bytes <= push ? 18'd1 : 18'd0;
      else if (push && (dl_bytes != '1)) dl_bytes <= dl_bytes + 1'b1;
      if (ioctl_download && ioctl_wr && idx_ok && !addr_ok) err_range <= 1'b1;
    end
  end

endmodule
